// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID/EX hazard inputs, scoreboard and bus-watchdog signals, plus
//            the per-register STALL/FLUSH vectors of hazard_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int NUM_STAGES  = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int MAX_PENDING = 4
) ();
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic                  ID_VALID;
  logic [REG_ADDR_W-1:0] ID_RS1_ADDR;
  logic [REG_ADDR_W-1:0] ID_RS2_ADDR;
  logic [REG_ADDR_W-1:0] ID_RD_ADDR;
  logic                  ID_RD_WE;
  logic                  ID_LONG_OP;
  logic                  EX_IS_LOAD;
  logic [REG_ADDR_W-1:0] EX_RD_ADDR;
  logic                  LONG_ISSUE;
  logic [REG_ADDR_W-1:0] LONG_ISSUE_RD;
  logic                  CMPL_VALID;
  logic [REG_ADDR_W-1:0] CMPL_RD;
  logic                  EX_PC_SRC;
  logic [NUM_STAGES-1:0] TRAP_VALID;
  logic                  AXIL_EN;
  logic                  AXIL_DONE;
  logic [NUM_STAGES-2:0] STALL;
  logic [NUM_STAGES-2:0] FLUSH;
  logic [CNT_W-1:0]      PENDING_CNT;
  logic                  BUS_TIMEOUT;

  modport master (
    output ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_RD_WE, ID_LONG_OP,
    output EX_IS_LOAD, EX_RD_ADDR, LONG_ISSUE, LONG_ISSUE_RD, CMPL_VALID, CMPL_RD,
    output EX_PC_SRC, TRAP_VALID, AXIL_EN, AXIL_DONE,
    input  STALL, FLUSH, PENDING_CNT, BUS_TIMEOUT
  );

  modport slave (
    input  ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_RD_WE, ID_LONG_OP,
    input  EX_IS_LOAD, EX_RD_ADDR, LONG_ISSUE, LONG_ISSUE_RD, CMPL_VALID, CMPL_RD,
    input  EX_PC_SRC, TRAP_VALID, AXIL_EN, AXIL_DONE,
    output STALL, FLUSH, PENDING_CNT, BUS_TIMEOUT
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Pipeline STALL/FLUSH generation with a long-latency write
//            scoreboard and an AXI-lite bus watchdog.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NUM_STAGES     = 5,
  parameter int EX_STAGE       = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int MAX_PENDING    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              CLK,
  input  logic              RST_N,
  hazard_scoreboard_if.slave bus
);
  localparam int NUM_REGS  = 2 ** REG_ADDR_W;
  localparam int NUM_PREGS = NUM_STAGES - 1;
  localparam int CNT_W     = $clog2(MAX_PENDING + 1);
  localparam int WD_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_REGS-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;

  logic [NUM_REGS-1:0]  w_cmpl_onehot;
  logic [NUM_REGS-1:0]  w_pend_eff;
  logic                 w_raw, w_waw, w_load_use, w_full, w_id_hold;
  logic                 w_bus_busy, w_bus_timeout, w_bus_wait;
  logic                 w_do_set, w_do_clr, w_same_reg;
  logic [NUM_PREGS-1:0] w_stall, w_flush;

  // Completion bypass: a same-cycle writeback already satisfies the reader.
  assign w_cmpl_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << bus.CMPL_RD;
  assign w_pend_eff    = pend_q & ~(w_cmpl_onehot & {NUM_REGS{bus.CMPL_VALID}});

  assign w_raw = bus.ID_VALID &
                 ((w_pend_eff[bus.ID_RS1_ADDR] & (|bus.ID_RS1_ADDR)) |
                  (w_pend_eff[bus.ID_RS2_ADDR] & (|bus.ID_RS2_ADDR)));
  assign w_waw = bus.ID_VALID & bus.ID_RD_WE & (|bus.ID_RD_ADDR) &
                 w_pend_eff[bus.ID_RD_ADDR];
  assign w_load_use = bus.ID_VALID & bus.EX_IS_LOAD & (|bus.EX_RD_ADDR) &
                      ((bus.ID_RS1_ADDR == bus.EX_RD_ADDR) |
                       (bus.ID_RS2_ADDR == bus.EX_RD_ADDR));
  assign w_full = bus.ID_VALID & bus.ID_LONG_OP & (cnt_q == CNT_MAX) &
                  ~bus.CMPL_VALID;
  assign w_id_hold = w_raw | w_waw | w_load_use | w_full;

  // The timeout cycle releases the stall so MEM can raise its access fault.
  assign w_bus_busy    = bus.AXIL_EN & ~bus.AXIL_DONE;
  assign w_bus_timeout = w_bus_busy & (wd_q == WD_LAST);
  assign w_bus_wait    = w_bus_busy & ~w_bus_timeout;

  always_comb begin
    w_stall = '0;
    w_flush = '0;
    for (int k = 0; k < NUM_PREGS; k++) begin
      w_stall[k] = w_bus_wait | ((k < EX_STAGE - 1) & w_id_hold);
      w_flush[k] = |(bus.TRAP_VALID >> (k + 2));
      if (k < EX_STAGE) begin
        w_flush[k] = w_flush[k] | (bus.EX_PC_SRC & ~w_bus_wait);
      end
      if (k == EX_STAGE - 1) begin
        w_flush[k] = w_flush[k] | (w_id_hold & ~w_bus_wait);
      end
    end
  end

  assign bus.STALL       = w_stall;
  assign bus.FLUSH       = w_flush;
  assign bus.PENDING_CNT = cnt_q;
  assign bus.BUS_TIMEOUT = w_bus_timeout;

  // An issue while full is dropped unless a completion frees a slot that cycle.
  assign w_do_clr   = bus.CMPL_VALID & (|bus.CMPL_RD) & pend_q[bus.CMPL_RD];
  assign w_same_reg = w_do_clr & (bus.CMPL_RD == bus.LONG_ISSUE_RD);
  assign w_do_set   = bus.LONG_ISSUE & (|bus.LONG_ISSUE_RD) &
                      ((cnt_q != CNT_MAX) | w_do_clr) &
                      (~pend_q[bus.LONG_ISSUE_RD] | w_same_reg);

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (w_do_clr) begin
      pend_d[bus.CMPL_RD] = 1'b0;
    end
    if (w_do_set) begin
      pend_d[bus.LONG_ISSUE_RD] = 1'b1;
    end
    case ({w_do_set, w_do_clr})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    wd_d = '0;
    if (w_bus_busy && !w_bus_timeout) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_q <= '0;
      cnt_q  <= '0;
      wd_q   <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      wd_q   <= wd_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Self-checking bench for hazard_scoreboard (5 stages, timeout 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;
  localparam int NS = 5;
  localparam int EXS = 2;
  localparam int AW = 5;
  localparam int MP = 4;
  localparam int TO = 4;

  typedef struct {
    bit          chk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, long_op, ex_load;
    logic [4:0]  ex_rd;
    logic        li;
    logic [4:0]  li_rd;
    logic        cv;
    logic [4:0]  c_rd;
    logic        pc_src;
    logic [4:0]  trap;
    logic        en, done;
  } stim_t;

  typedef struct {
    logic [3:0] stall;
    logic [3:0] flush;
    logic [2:0] cnt;
    logic       to;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_checks = 0;
  int   n_errors = 0;
  stim_t stim_q[$];
  exp_t  ref_q[$];
  exp_t  score_q[$];

  always #5 CLK = ~CLK;

  hazard_scoreboard_if #(.NUM_STAGES(NS), .REG_ADDR_W(AW), .MAX_PENDING(MP)) hs ();

  hazard_scoreboard #(
    .NUM_STAGES(NS), .EX_STAGE(EXS), .REG_ADDR_W(AW),
    .MAX_PENDING(MP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (hs)
  );

  function automatic stim_t S();
    stim_t s;
    s.chk = 1'b1; s.rst_n = 1'b1; s.id_valid = 1'b0;
    s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.rd_we = 1'b0; s.long_op = 1'b0;
    s.ex_load = 1'b0; s.ex_rd = '0; s.li = 1'b0; s.li_rd = '0;
    s.cv = 1'b0; s.c_rd = '0; s.pc_src = 1'b0; s.trap = '0;
    s.en = 1'b0; s.done = 1'b0;
    return s;
  endfunction

  function automatic stim_t R();
    stim_t s = S();
    s.chk = 1'b0; s.rst_n = 1'b0;
    return s;
  endfunction

  function automatic exp_t E(logic [3:0] st, logic [3:0] fl, int cnt, logic to);
    exp_t e;
    e.stall = st; e.flush = fl; e.cnt = 3'(cnt); e.to = to;
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    ref_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    RST_N            = s.rst_n;
    hs.ID_VALID      = s.id_valid;
    hs.ID_RS1_ADDR   = s.rs1;
    hs.ID_RS2_ADDR   = s.rs2;
    hs.ID_RD_ADDR    = s.rd;
    hs.ID_RD_WE      = s.rd_we;
    hs.ID_LONG_OP    = s.long_op;
    hs.EX_IS_LOAD    = s.ex_load;
    hs.EX_RD_ADDR    = s.ex_rd;
    hs.LONG_ISSUE    = s.li;
    hs.LONG_ISSUE_RD = s.li_rd;
    hs.CMPL_VALID    = s.cv;
    hs.CMPL_RD       = s.c_rd;
    hs.EX_PC_SRC     = s.pc_src;
    hs.TRAP_VALID    = s.trap;
    hs.AXIL_EN       = s.en;
    hs.AXIL_DONE     = s.done;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    s = R(); s.li = 1; s.li_rd = 3; s.en = 1; s.id_valid = 1; s.rs1 = 3;
    add(s, E(0, 0, 0, 0));
    add(S(), E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.id_valid = 1; s.rs1 = 3; s.rd = 3; s.rd_we = 1;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL reset step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  task automatic test_load_use();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    s = S(); s.id_valid = 1; s.ex_load = 1; s.ex_rd = 5; s.rs2 = 5;
    add(s, E(4'b0001, 4'b0010, 0, 0));
    s = S(); s.id_valid = 1; s.ex_load = 1; s.ex_rd = 0;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.id_valid = 0; s.ex_load = 1; s.ex_rd = 5; s.rs2 = 5;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.id_valid = 1; s.ex_load = 0; s.ex_rd = 5; s.rs2 = 5;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.id_valid = 1; s.ex_load = 1; s.ex_rd = 5; s.rs1 = 5;
    add(s, E(4'b0001, 4'b0010, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL load_use step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  task automatic test_scoreboard_raw();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    s = S(); s.li = 1; s.li_rd = 7;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.id_valid = 1; s.rs1 = 7;
    add(s, E(4'b0001, 4'b0010, 1, 0));
    add(s, E(4'b0001, 4'b0010, 1, 0));
    s.cv = 1; s.c_rd = 7;
    add(s, E(4'b0000, 4'b0000, 1, 0));
    s.cv = 0;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.li = 1; s.li_rd = 7;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s = S(); s.id_valid = 1; s.rd = 7; s.rd_we = 1;
    add(s, E(4'b0001, 4'b0010, 1, 0));
    s.rd_we = 0;
    add(s, E(4'b0000, 4'b0000, 1, 0));
    s = S(); s.id_valid = 1; s.rs2 = 7;
    add(s, E(4'b0001, 4'b0010, 1, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL scoreboard_raw step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  task automatic test_full();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    for (int r = 1; r <= 4; r++) begin
      s = S(); s.li = 1; s.li_rd = 5'(r);
      add(s, E(4'b0000, 4'b0000, r - 1, 0));
    end
    s = S(); s.li = 1; s.li_rd = 9;
    add(s, E(4'b0000, 4'b0000, 4, 0));
    s = S(); s.id_valid = 1; s.rs1 = 9;
    add(s, E(4'b0000, 4'b0000, 4, 0));
    s = S(); s.id_valid = 1; s.long_op = 1;
    add(s, E(4'b0001, 4'b0010, 4, 0));
    s.cv = 1; s.c_rd = 2;
    add(s, E(4'b0000, 4'b0000, 4, 0));
    add(S(), E(4'b0000, 4'b0000, 3, 0));
    s = S(); s.cv = 1; s.c_rd = 9;
    add(s, E(4'b0000, 4'b0000, 3, 0));
    s = S(); s.li = 1; s.li_rd = 5; s.cv = 1; s.c_rd = 1;
    add(s, E(4'b0000, 4'b0000, 3, 0));
    s = S(); s.li = 1; s.li_rd = 3; s.cv = 1; s.c_rd = 3;
    add(s, E(4'b0000, 4'b0000, 3, 0));
    s = S(); s.id_valid = 1; s.rs1 = 5;
    add(s, E(4'b0001, 4'b0010, 3, 0));
    s = S(); s.id_valid = 1; s.rs2 = 1;
    add(s, E(4'b0000, 4'b0000, 3, 0));
    s = S(); s.id_valid = 1; s.rs1 = 3;
    add(s, E(4'b0001, 4'b0010, 3, 0));
    s = S(); s.li = 1; s.li_rd = 0;
    add(s, E(4'b0000, 4'b0000, 3, 0));
    add(S(), E(4'b0000, 4'b0000, 3, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL full step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  task automatic test_branch_bus();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    s = S(); s.en = 1; s.pc_src = 1;
    add(s, E(4'b1111, 4'b0000, 0, 0));
    s.done = 1;
    add(s, E(4'b0000, 4'b0011, 0, 0));
    s = S(); s.en = 1; s.id_valid = 1; s.ex_load = 1; s.ex_rd = 5; s.rs1 = 5;
    add(s, E(4'b1111, 4'b0000, 0, 0));
    s.en = 0;
    add(s, E(4'b0001, 4'b0010, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL branch_bus step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  task automatic test_trap();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    s = S(); s.trap = 5'b01000;
    add(s, E(4'b0000, 4'b0011, 0, 0));
    s.trap = 5'b10000;
    add(s, E(4'b0000, 4'b0111, 0, 0));
    s.trap = 5'b00100;
    add(s, E(4'b0000, 4'b0001, 0, 0));
    s.trap = 5'b00011;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    s.trap = 5'b01000; s.en = 1;
    add(s, E(4'b1111, 4'b0011, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL trap step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  task automatic test_watchdog();
    stim_t s; exp_t e, got; int idx = 0;
    add(R(), E(0, 0, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      s = S(); s.en = 1;
      if (i == 1) begin s.li = 1; s.li_rd = 6; end
      if (i % TO == 0) add(s, E(4'b0000, 4'b0000, (i == 1) ? 0 : 1, 1));
      else             add(s, E(4'b1111, 4'b0000, (i == 1) ? 0 : 1, 0));
    end
    s = R(); s.en = 1;
    add(s, E(0, 0, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      s = S(); s.en = 1;
      if (i % TO == 0) add(s, E(4'b0000, 4'b0000, 0, 1));
      else             add(s, E(4'b1111, 4'b0000, 0, 0));
    end
    s = S(); s.id_valid = 1; s.rs1 = 6;
    add(s, E(4'b0000, 4'b0000, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = ref_q.pop_front();
      @(posedge CLK); #1; drive(s);
      if (s.chk) score_q.push_back(e);
      @(negedge CLK);
      if (s.chk) begin
        got = score_q.pop_front(); n_checks++;
        if (hs.STALL !== got.stall || hs.FLUSH !== got.flush ||
            hs.PENDING_CNT !== got.cnt || hs.BUS_TIMEOUT !== got.to) begin
          n_errors++;
          $display("FAIL watchdog step %0d: got stall=%b flush=%b cnt=%0d to=%b, expected stall=%b flush=%b cnt=%0d to=%b",
                   idx, hs.STALL, hs.FLUSH, hs.PENDING_CNT, hs.BUS_TIMEOUT, got.stall, got.flush, got.cnt, got.to);
        end
      end
      idx++;
    end
  endtask

  initial begin
    drive(R());
    test_reset();
    test_load_use();
    test_scoreboard_raw();
    test_full();
    test_branch_bus();
    test_trap();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "global time limit reached");
  end
endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the core's combinational hazard logic. It generates per-pipeline-register stall and flush vectors for an N-stage pipeline. It adds a register scoreboard for multi-cycle writers (AXI-lite loads, iterative mul/div) and a bus watchdog that ends a hung AXI-lite transaction. It sits beside the ID stage and drives every pipeline register's STALL/FLUSH input.

## Interface
Parameters:
- NUM_STAGES, 5, pipeline stages (IF=0 … WB=NUM_STAGES-1); pipeline register k sits between stage k and k+1; min 4
- EX_STAGE, 2, index of the stage that resolves branches/jumps
- REG_ADDR_W, 5, register address width; scoreboard holds 2**REG_ADDR_W bits, register 0 never tracked
- MAX_PENDING, 4, max outstanding long-latency writes; min 1
- TIMEOUT_CYCLES, 256, bus wait cycles before watchdog fires; min 2

Ports:
- CLK  in  1  clock
- RST_N  in  1  synchronous active-low reset
- ID_VALID  in  1  valid instruction in ID
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  REG_ADDR_W  ID source/dest registers
- ID_RD_WE  in  1  ID instruction writes RD
- ID_LONG_OP  in  1  ID instruction is a long-latency writer
- EX_IS_LOAD  in  1  EX holds a single-cycle-forwarded load (classic load-use)
- EX_RD_ADDR  in  REG_ADDR_W  EX destination
- LONG_ISSUE  in  1  long op leaves the last flushable stage (commit point); sets pending
- LONG_ISSUE_RD  in  REG_ADDR_W  its destination
- CMPL_VALID  in  1  long-op result written back; clears pending
- CMPL_RD  in  REG_ADDR_W  completed destination
- EX_PC_SRC  in  1  redirect taken in EX_STAGE
- TRAP_VALID  in  NUM_STAGES  per-stage trap
- AXIL_EN  in  1  AXI-lite transaction in flight in MEM
- AXIL_DONE  in  1  read or write response accepted
- STALL  out  NUM_STAGES-1  hold pipeline register k
- FLUSH  out  NUM_STAGES-1  bubble pipeline register k
- PENDING_CNT  out  $clog2(MAX_PENDING+1)  outstanding long ops
- BUS_TIMEOUT  out  1  one-cycle watchdog pulse

## Operation
Internal signals:
- bus_wait = AXIL_EN & ~AXIL_DONE & ~BUS_TIMEOUT
- pend[r] is the scoreboard bit for register r
- pend_eff = pend with bit CMPL_RD cleared when CMPL_VALID (completion bypass)

Hazard terms, each gated by ID_VALID:
- raw: (pend_eff[RS1] & RS1≠0) | (pend_eff[RS2] & RS2≠0)
- waw: ID_RD_WE & RD≠0 & pend_eff[RD]
- load_use: EX_IS_LOAD & EX_RD≠0 & (RS1==EX_RD | RS2==EX_RD)
- full: ID_LONG_OP & PENDING_CNT==MAX_PENDING & ~CMPL_VALID
- id_hold = raw | waw | load_use | full

Outputs:
- STALL[k] = bus_wait for every k. Additionally STALL[k] |= id_hold for k < EX_STAGE-1.
- FLUSH[k] = |TRAP_VALID[NUM_STAGES-1:k+2].
- FLUSH[k] |= (EX_PC_SRC & ~bus_wait) for k < EX_STAGE.
- FLUSH[EX_STAGE-1] |= id_hold & ~bus_wait.
- FLUSH has priority over STALL at the register.

Scoreboard update:
- On LONG_ISSUE with LONG_ISSUE_RD≠0: set the bit, count +1.
- On CMPL_VALID with CMPL_RD≠0 and that bit set: clear the bit, count −1.
- Same-cycle set and clear of different registers: both apply, count unchanged.
- Same-cycle set and clear of the same register: bit stays set, count unchanged.
- CMPL to a non-pending register: ignored.
- LONG_ISSUE when full: protocol error, no update.

Watchdog:
- Counter runs while AXIL_EN & ~AXIL_DONE; clears on AXIL_DONE or ~AXIL_EN.
- At count TIMEOUT_CYCLES-1 it asserts BUS_TIMEOUT for exactly one cycle and clears.
- bus_wait is forced low during that cycle, so the pipeline advances and MEM raises the access-fault trap.

## Timing
- Reset (RST_N=0 at a CLK edge): pend=0, PENDING_CNT=0, watchdog=0, BUS_TIMEOUT=0.
- Reset takes precedence over all same-cycle events.
- STALL and FLUSH are combinational from inputs and registered state. With all inputs 0 after reset, both are 0.
- Scoreboard and count update at the CLK edge after LONG_ISSUE/CMPL. The completion bypass makes a same-cycle CMPL release the stall with zero added latency.
- Watchdog fires on the TIMEOUT_CYCLES-th consecutive waiting cycle, i.e. BUS_TIMEOUT high in that cycle.
- Reset mid-transaction discards all pending state with no completion required.

## Test plan
- Load-use: EX_IS_LOAD=1, EX_RD=5, ID_RS2=5 -> STALL[0]=1, FLUSH[1]=1 for one cycle; EX_RD=0 -> no stall.
- Scoreboard RAW: LONG_ISSUE rd=7, then ID_RS1=7 held -> STALL[0] stays 1 until the cycle CMPL_VALID rd=7, in which STALL[0]=0. PENDING_CNT goes 1→0.
- Full: four LONG_ISSUE to regs 1–4, ID_LONG_OP=1 -> stall. CMPL rd=2 the same cycle -> no stall. PENDING_CNT=4 then 3.
- Branch during bus stall: AXIL_EN=1, EX_PC_SRC=1 -> FLUSH[0..EX_STAGE-1]=0 and all STALL=1. AXIL_DONE=1 next cycle -> FLUSH[0],FLUSH[1]=1.
- Trap: TRAP_VALID[3]=1 -> FLUSH[0..1]=1, FLUSH[2..3]=0. TRAP_VALID[4]=1 -> FLUSH[0..2]=1.
- Watchdog with TIMEOUT_CYCLES=4: AXIL_EN held and no DONE -> BUS_TIMEOUT pulses on the 4th cycle with STALL=0 that cycle, then recounts. Asserting RST_N=0 mid-count -> counter=0 and scoreboard clear.
